// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the IF-stage sequencer and the BTB/PC block.
package fetch_ctrl_pkg;

  localparam int unsigned BTB_ENTRIES_DEF  = 512;
  localparam int unsigned BTB_IDX_W        = 9;
  localparam int unsigned IMEM_TIMEOUT_DEF = 255;

  typedef enum logic [2:0] {
    ST_BOOT      = 3'd0,
    ST_FETCH     = 3'd1,
    ST_WAIT_IMEM = 3'd2,
    ST_REDIRECT  = 3'd3,
    ST_BTB_FLUSH = 3'd4
  } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Control bundle between fetch_ctrl (master) and hazard unit / fetch datapath (slave).
// Perf counter signals exist only when FETCH_CTRL_PERF_EN is defined.
interface fetch_ctrl_if
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned BTB_ENTRIES = BTB_ENTRIES_DEF
);
  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);

  logic             mispredict;
  logic             fence_i;
  logic             load_use_hazard;
  logic             imem_req_ready;
  logic             pc_enable;
  logic             ifid_stall;
  logic             ifid_flush;
  logic             idex_flush;
  logic             btb_inv_valid;
  logic [IDX_W-1:0] btb_inv_index;
  logic             ctrl_busy;
  logic             imem_timeout;
`ifdef FETCH_CTRL_PERF_EN
  logic [31:0]      perf_mispredicts;
  logic [31:0]      perf_stall_cycles;
  logic [31:0]      perf_flush_cycles;
`endif

  modport master (
`ifdef FETCH_CTRL_PERF_EN
    output perf_mispredicts, perf_stall_cycles, perf_flush_cycles,
`endif
    input  mispredict, fence_i, load_use_hazard, imem_req_ready,
    output pc_enable, ifid_stall, ifid_flush, idex_flush,
    output btb_inv_valid, btb_inv_index, ctrl_busy, imem_timeout
  );

  modport slave (
`ifdef FETCH_CTRL_PERF_EN
    input  perf_mispredicts, perf_stall_cycles, perf_flush_cycles,
`endif
    output mispredict, fence_i, load_use_hazard, imem_req_ready,
    input  pc_enable, ifid_stall, ifid_flush, idex_flush,
    input  btb_inv_valid, btb_inv_index, ctrl_busy, imem_timeout
  );

endinterface

// File: rtl/btb_flush_sweeper.sv
// Walks every BTB set once after a start pulse, emitting one invalidate per cycle.
module btb_flush_sweeper #(
  parameter int unsigned ENTRIES = 512
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  output logic                       busy,
  output logic                       inv_valid,
  output logic [$clog2(ENTRIES)-1:0] inv_index,
  output logic                       done
);
  localparam int unsigned      IDX_W = $clog2(ENTRIES);
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(ENTRIES - 1);

  logic             busy_q;
  logic [IDX_W-1:0] idx_q;

  // Start is ignored while a sweep is already running.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      idx_q  <= '0;
    end else if (busy_q) begin
      if (idx_q == LAST) begin
        busy_q <= 1'b0;
        idx_q  <= '0;
      end else begin
        idx_q <= idx_q + IDX_W'(1);
      end
    end else if (start) begin
      busy_q <= 1'b1;
    end
  end

  assign busy      = busy_q;
  assign inv_valid = busy_q;
  assign inv_index = idx_q;
  assign done      = busy_q && (idx_q == LAST);

endmodule

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: PC enable, IF/ID + ID/EX stall/flush, FENCE.I BTB sweep.
// Define FETCH_CTRL_PERF_EN to add the perf_* event counters.
module fetch_ctrl
  import fetch_ctrl_pkg::*;
#(
  parameter int unsigned BTB_ENTRIES      = BTB_ENTRIES_DEF,
  parameter int unsigned REDIRECT_BUBBLES = 1,
  parameter int unsigned IMEM_TIMEOUT     = IMEM_TIMEOUT_DEF
) (
  input logic          clk,
  input logic          rst_n,
  fetch_ctrl_if.master bus
);
  localparam int unsigned IDX_W = $clog2(BTB_ENTRIES);
  localparam int unsigned TMO_W = $clog2(IMEM_TIMEOUT + 1);
  localparam int unsigned BUB_W = 2;

  localparam logic [TMO_W-1:0] TMO_MAX    = TMO_W'(IMEM_TIMEOUT);
  localparam logic [BUB_W-1:0] BUB_RELOAD = BUB_W'(REDIRECT_BUBBLES - 1);

  localparam logic [2:0] S_BOOT      = ST_BOOT;
  localparam logic [2:0] S_FETCH     = ST_FETCH;
  localparam logic [2:0] S_WAIT_IMEM = ST_WAIT_IMEM;
  localparam logic [2:0] S_REDIRECT  = ST_REDIRECT;
  localparam logic [2:0] S_BTB_FLUSH = ST_BTB_FLUSH;

  logic [2:0]       state_q, state_d;
  logic [BUB_W-1:0] bub_q, bub_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             tmo_flag_q, tmo_flag_d;

  logic             pc_enable, ifid_stall, ifid_flush, idex_flush;
  logic             sweep_start, sweep_busy, sweep_valid, sweep_done;
  logic [IDX_W-1:0] sweep_index;

  logic mis, fence, load_use, ready;
  assign mis      = bus.mispredict;
  assign fence    = bus.fence_i;
  assign load_use = bus.load_use_hazard;
  assign ready    = bus.imem_req_ready;

  btb_flush_sweeper #(.ENTRIES(BTB_ENTRIES)) u_sweeper (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (sweep_start),
    .busy      (sweep_busy),
    .inv_valid (sweep_valid),
    .inv_index (sweep_index),
    .done      (sweep_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_BOOT;
      bub_q      <= '0;
      tmo_q      <= '0;
      tmo_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      bub_q      <= bub_d;
      tmo_q      <= tmo_d;
      tmo_flag_q <= tmo_flag_d;
    end
  end

  // Next state and Mealy control outputs.
  always_comb begin
    state_d     = state_q;
    bub_d       = bub_q;
    tmo_d       = tmo_q;
    tmo_flag_d  = tmo_flag_q;
    sweep_start = 1'b0;
    pc_enable   = 1'b0;
    ifid_stall  = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;

    case (state_q)
      S_BOOT: state_d = S_FETCH;

      S_FETCH: begin
        if (mis) begin
          pc_enable  = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          if (REDIRECT_BUBBLES > 1) begin
            state_d = S_REDIRECT;
            bub_d   = BUB_RELOAD;
          end
        end else if (fence) begin
          ifid_flush  = 1'b1;
          idex_flush  = 1'b1;
          sweep_start = 1'b1;
          state_d     = S_BTB_FLUSH;
        end else if (load_use) begin
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end else if (!ready) begin
          ifid_flush = 1'b1;
          tmo_d      = '0;
          state_d    = S_WAIT_IMEM;
        end else begin
          pc_enable = 1'b1;
        end
      end

      S_WAIT_IMEM: begin
        ifid_flush = 1'b1;
        if (tmo_q != TMO_MAX) tmo_d = tmo_q + TMO_W'(1);
        if (tmo_d == TMO_MAX) tmo_flag_d = 1'b1;
        if (mis) begin
          pc_enable  = 1'b1;
          idex_flush = 1'b1;
        end else if (ready) begin
          state_d = S_FETCH;
        end
      end

      S_REDIRECT: begin
        ifid_flush = 1'b1;
        pc_enable  = ready;
        if (mis) begin
          idex_flush = 1'b1;
          bub_d      = BUB_RELOAD;
        end else if (bub_q <= BUB_W'(1)) begin
          bub_d   = '0;
          state_d = S_FETCH;
        end else begin
          bub_d = bub_q - BUB_W'(1);
        end
      end

      S_BTB_FLUSH: begin
        // A redirect punches a single-cycle hole in the stall; the sweep keeps going.
        if (mis) begin
          pc_enable  = 1'b1;
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else begin
          ifid_stall = 1'b1;
        end
        if (sweep_done) state_d = S_FETCH;
      end

      default: state_d = S_BOOT;
    endcase
  end

  assign bus.pc_enable     = pc_enable;
  assign bus.ifid_stall    = ifid_stall;
  assign bus.ifid_flush    = ifid_flush;
  assign bus.idex_flush    = idex_flush;
  assign bus.btb_inv_valid = sweep_valid;
  assign bus.btb_inv_index = sweep_index;
  assign bus.ctrl_busy     = (state_q != S_FETCH);
  assign bus.imem_timeout  = tmo_flag_q;

  stall_flush_excl: assert property (@(posedge clk) disable iff (!rst_n)
    !(ifid_stall && ifid_flush));

  sweep_tracks_state: assert property (@(posedge clk) disable iff (!rst_n)
    (state_q == S_BTB_FLUSH) == sweep_busy);

`ifdef FETCH_CTRL_PERF_EN
  logic [31:0] perf_mis_q, perf_stall_q, perf_flush_q;

  // Free-running event counters; wrap naturally at 2^32.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_mis_q   <= '0;
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (mis)        perf_mis_q   <= perf_mis_q + 32'd1;
      if (!pc_enable) perf_stall_q <= perf_stall_q + 32'd1;
      if (ifid_flush) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign bus.perf_mispredicts  = perf_mis_q;
  assign bus.perf_stall_cycles = perf_stall_q;
  assign bus.perf_flush_cycles = perf_flush_q;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl built with REDIRECT_BUBBLES=2, 512 BTB sets, timeout 255.
module tb_fetch_ctrl;
  import fetch_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  fetch_ctrl_if #(.BTB_ENTRIES(512)) bus ();

  fetch_ctrl #(
    .BTB_ENTRIES      (512),
    .REDIRECT_BUBBLES (2),
    .IMEM_TIMEOUT     (255)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // {pc_enable, ifid_stall, ifid_flush, idex_flush, btb_inv_valid, ctrl_busy}
  logic [5:0] obs;
  assign obs = {bus.pc_enable, bus.ifid_stall, bus.ifid_flush, bus.idex_flush,
                bus.btb_inv_valid, bus.ctrl_busy};

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  // s = {mispredict, fence_i, load_use_hazard, imem_req_ready}
  task automatic drive(input logic [3:0] s);
    bus.mispredict      = s[3];
    bus.fence_i         = s[2];
    bus.load_use_hazard = s[1];
    bus.imem_req_ready  = s[0];
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(4'b0001);
    next_cycle();
    next_cycle();
    settle();
    total++;
    if (obs[5:1] !== 5'b00000 || bus.btb_inv_index !== 9'd0 || bus.imem_timeout !== 1'b0) begin
      bad++;
      $display("FAIL reset_outputs: got ctl=%b idx=%0d tmo=%b, want ctl=00000 idx=0 tmo=0",
               obs[5:1], bus.btb_inv_index, bus.imem_timeout);
    end
    next_cycle();
    rst_n = 1'b1;
    settle();
    total++;
    if (obs !== 6'b000001) begin
      bad++;
      $display("FAIL boot_cycle: got %b, want 000001", obs);
    end
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      settle();
      total++;
      if (obs !== 6'b100000) begin
        bad++;
        $display("FAIL fetch_run[%0d]: got %b, want 100000", i, obs);
      end
    end
  endtask

  task automatic test_mispredict();
    logic [3:0] stim [7] = '{4'b1001, 4'b0001, 4'b0001, 4'b1001, 4'b1001, 4'b0000, 4'b0001};
    logic [5:0] want [7] = '{6'b101100, 6'b101001, 6'b100000, 6'b101100, 6'b101101,
                             6'b001001, 6'b100000};
    for (int i = 0; i < 7; i++) begin
      next_cycle();
      drive(stim[i]);
      settle();
      total++;
      if (obs !== want[i]) begin
        bad++;
        $display("FAIL mispredict[%0d]: got %b, want %b", i, obs, want[i]);
      end
    end
  endtask

  task automatic test_load_use();
    logic [3:0] stim [3] = '{4'b0011, 4'b0011, 4'b0001};
    logic [5:0] want [3] = '{6'b010100, 6'b010100, 6'b100000};
    for (int i = 0; i < 3; i++) begin
      next_cycle();
      drive(stim[i]);
      settle();
      total++;
      if (obs !== want[i]) begin
        bad++;
        $display("FAIL load_use[%0d]: got %b, want %b", i, obs, want[i]);
      end
    end
  endtask

  task automatic test_fence_sweep();
    logic [5:0] want;
    next_cycle();
    drive(4'b0101);
    settle();
    total++;
    if (obs !== 6'b001100) begin
      bad++;
      $display("FAIL fence_issue: got %b, want 001100", obs);
    end
    for (int k = 0; k < 512; k++) begin
      next_cycle();
      drive(k == 100 ? 4'b1001 : (k == 200 ? 4'b0101 : 4'b0001));
      settle();
      want = (k == 100) ? 6'b101111 : 6'b010011;
      total++;
      if (obs !== want || bus.btb_inv_index !== 9'(k)) begin
        bad++;
        $display("FAIL sweep[%0d]: got ctl=%b idx=%0d, want ctl=%b idx=%0d",
                 k, obs, bus.btb_inv_index, want, k);
      end
    end
    next_cycle();
    drive(4'b0001);
    settle();
    total++;
    if (obs !== 6'b100000 || bus.btb_inv_index !== 9'd0) begin
      bad++;
      $display("FAIL fence_resume: got ctl=%b idx=%0d, want 100000 idx=0", obs, bus.btb_inv_index);
    end
  endtask

  task automatic test_mis_and_fence();
    logic [3:0] stim [4] = '{4'b1101, 4'b0001, 4'b0001, 4'b0001};
    logic [5:0] want [4] = '{6'b101100, 6'b101001, 6'b100000, 6'b100000};
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      drive(stim[i]);
      settle();
      total++;
      if (obs !== want[i]) begin
        bad++;
        $display("FAIL mis_and_fence[%0d]: got %b, want %b", i, obs, want[i]);
      end
    end
  endtask

  task automatic test_imem_timeout();
    logic [5:0] want;
    logic       want_tmo;
    for (int n = 0; n < 302; n++) begin
      next_cycle();
      drive({n == 50, 1'b0, 1'b0, n >= 300});
      settle();
      if (n == 0)        want = 6'b001000;
      else if (n == 50)  want = 6'b101101;
      else if (n == 301) want = 6'b100000;
      else               want = 6'b001001;
      want_tmo = (n >= 256);
      total++;
      if (obs !== want || bus.imem_timeout !== want_tmo) begin
        bad++;
        $display("FAIL imem_wait[%0d]: got ctl=%b tmo=%b, want ctl=%b tmo=%b",
                 n, obs, bus.imem_timeout, want, want_tmo);
      end
    end
  endtask

  task automatic test_reset_mid_sweep();
    next_cycle();
    drive(4'b0101);
    for (int i = 0; i < 20; i++) begin
      next_cycle();
      drive(4'b0001);
    end
    settle();
    total++;
    if (obs !== 6'b010011 || bus.btb_inv_index !== 9'd19 || bus.imem_timeout !== 1'b1) begin
      bad++;
      $display("FAIL pre_abort: got ctl=%b idx=%0d tmo=%b, want 010011 idx=19 tmo=1",
               obs, bus.btb_inv_index, bus.imem_timeout);
    end
    next_cycle();
    rst_n = 1'b0;
    settle();
    total++;
    if (obs[5:1] !== 5'b00000 || bus.btb_inv_index !== 9'd0 || bus.imem_timeout !== 1'b0) begin
      bad++;
      $display("FAIL abort_reset: got ctl=%b idx=%0d tmo=%b, want 00000 idx=0 tmo=0",
               obs[5:1], bus.btb_inv_index, bus.imem_timeout);
    end
    next_cycle();
    rst_n = 1'b1;
    settle();
    total++;
    if (obs !== 6'b000001) begin
      bad++;
      $display("FAIL abort_boot: got %b, want 000001", obs);
    end
    next_cycle();
    settle();
    total++;
    if (obs !== 6'b100000 || bus.imem_timeout !== 1'b0) begin
      bad++;
      $display("FAIL abort_fetch: got ctl=%b tmo=%b, want 100000 tmo=0", obs, bus.imem_timeout);
    end
  endtask

  initial begin
    test_reset();
    test_mispredict();
    test_load_use();
    test_fence_sweep();
    test_mis_and_fence();
    test_imem_timeout();
    test_reset_mid_sweep();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
